// File: rtl/ctrl_mc_param.sv
// rtl/ctrl_mc_param.sv - parametrised multicycle control unit
// Moore-style decode of estado qualified by opcode, zero, mem_ready and stack flags.

module ctrl_mc_param #(
   parameter int OPW         = 6,
   parameter int FW          = 6,
   parameter int MEM_WAIT    = 1,
   parameter int HALT_RESUME = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OPW-1:0]   opcode,
   input  logic             zero,
   input  logic             enter,
   input  logic             mem_ready,
   input  logic             stk_full,
   input  logic             stk_empty,
   output logic [3:0]       estado,
   output logic             EscrevePC,
   output logic             EscreveRI,
   output logic             EscreveReg,
   output logic             EscreveMem,
   output logic             controleOUT,
   output logic             push,
   output logic             pop,
   output logic             mem_req,
   output logic             SelMuxMem,
   output logic             SelMuxReg1,
   output logic             SelMuxReg2,
   output logic             SelMuxUlaA,
   output logic             SelMuxIn,
   output logic [1:0]       SelMuxUlaB,
   output logic [1:0]       SelMuxPC,
   output logic [1:0]       OpULA,
   output logic             erro,
   output logic [CNT_W-1:0] instr_cnt
);

   if (OPW < 5 || FW < 1) begin : g_param_check
      $error("ctrl_mc_param: OPW must hold the ISA codes and FW must be non-zero");
   end

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_ADDR      = 4'd2,
      S_MEM_RD    = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WR    = 4'd5,
      S_EXEC_R    = 4'd6,
      S_WB        = 4'd7,
      S_BR_ADDR   = 4'd8,
      S_JUMP      = 4'd9,
      S_BR_COMMIT = 4'd10,
      S_EXEC_I    = 4'd11,
      S_IN_WAIT   = 4'd12,
      S_IN_WB     = 4'd13,
      S_HALT      = 4'd14,
      S_UNUSED    = 4'd15
   } state_t;

   localparam logic [OPW-1:0]   OP_R   = OPW'('h00);
   localparam logic [OPW-1:0]   OP_BEQ = OPW'('h0A);
   localparam logic [OPW-1:0]   OP_BGT = OPW'('h0D);
   localparam logic [OPW-1:0]   OP_STI = OPW'('h0E);
   localparam logic [OPW-1:0]   OP_LDI = OPW'('h0F);
   localparam logic [OPW-1:0]   OP_STR = OPW'('h10);
   localparam logic [OPW-1:0]   OP_LDR = OPW'('h11);
   localparam logic [OPW-1:0]   OP_HLT = OPW'('h12);
   localparam logic [OPW-1:0]   OP_IN  = OPW'('h13);
   localparam logic [OPW-1:0]   OP_OUT = OPW'('h14);
   localparam logic [OPW-1:0]   OP_JMP = OPW'('h15);
   localparam logic [OPW-1:0]   OP_JAL = OPW'('h16);
   localparam logic [OPW-1:0]   OP_JST = OPW'('h17);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_next;
   logic             r_erro;
   logic             r_enter_q;
   logic [CNT_W-1:0] r_cnt;
   logic             w_fault;
   logic             w_rdy;
   logic             w_enter_rise;
   logic             w_is_br;
   logic             w_is_load;
   logic             w_is_store;
   logic             w_is_imm_mem;

   assign w_rdy        = (MEM_WAIT != 0) ? mem_ready : 1'b1;
   assign w_enter_rise = enter & ~r_enter_q;
   assign w_is_br      = (opcode >= OP_BEQ) && (opcode <= OP_BGT);
   assign w_is_load    = (opcode == OP_LDI) || (opcode == OP_LDR);
   assign w_is_store   = (opcode == OP_STI) || (opcode == OP_STR);
   assign w_is_imm_mem = (opcode == OP_STI) || (opcode == OP_LDI);

   assign estado    = r_state;
   assign erro      = r_erro;
   assign instr_cnt = r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_erro    <= 1'b0;
         r_enter_q <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_next;
         r_erro    <= r_erro | w_fault;
         r_enter_q <= enter;
         if (r_state == S_DECODE && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      w_fault     = 1'b0;
      EscrevePC   = 1'b0;
      EscreveRI   = 1'b0;
      EscreveReg  = 1'b0;
      EscreveMem  = 1'b0;
      controleOUT = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      mem_req     = 1'b0;
      SelMuxMem   = 1'b0;
      SelMuxReg1  = 1'b0;
      SelMuxReg2  = 1'b0;
      SelMuxUlaA  = 1'b0;
      SelMuxIn    = 1'b0;
      SelMuxUlaB  = 2'b00;
      SelMuxPC    = 2'b00;
      OpULA       = 2'b00;
      case (r_state)
         S_FETCH: begin
            // Reset forces FETCH, so EscreveRI is the only enable that must be masked
            mem_req    = 1'b1;
            EscreveRI  = w_rdy & ~reset;
            SelMuxUlaB = 2'b01;
            OpULA      = 2'b01;
            SelMuxIn   = 1'b1;
            if (w_rdy) w_next = S_DECODE;
         end
         S_DECODE: begin
            EscrevePC   = (opcode != OP_HLT);
            SelMuxUlaB  = 2'b01;
            controleOUT = (opcode == OP_OUT);
            if (opcode == OP_OUT)                        w_next = S_FETCH;
            else if (opcode == OP_IN)                    w_next = S_IN_WAIT;
            else if (w_is_load || w_is_store)            w_next = S_ADDR;
            else if (opcode == OP_R)                     w_next = S_EXEC_R;
            else if (w_is_br)                            w_next = S_BR_ADDR;
            else if (opcode == OP_JMP || opcode == OP_JAL) w_next = S_JUMP;
            else if (opcode == OP_JST)                   w_next = S_BR_COMMIT;
            else if (opcode == OP_HLT)                   w_next = S_HALT;
            else                                         w_next = S_EXEC_I;
         end
         S_ADDR: begin
            SelMuxMem  = 1'b1;
            SelMuxUlaA = 1'b1;
            SelMuxUlaB = 2'b11;
            OpULA      = w_is_imm_mem ? 2'b11 : 2'b01;
            w_next     = w_is_load ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req    = 1'b1;
            SelMuxMem  = 1'b1;
            SelMuxReg2 = 1'b1;
            if (w_rdy) w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            EscreveReg = 1'b1;
            SelMuxMem  = 1'b1;
            SelMuxReg2 = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEM_WR: begin
            // Write strobe is held through wait cycles; memory commits on the rdy cycle
            mem_req    = 1'b1;
            EscreveMem = 1'b1;
            SelMuxMem  = 1'b1;
            SelMuxUlaA = 1'b1;
            OpULA      = 2'b11;
            if (w_rdy) w_next = S_FETCH;
         end
         S_EXEC_R: begin
            SelMuxReg1 = 1'b1;
            SelMuxUlaA = 1'b1;
            w_next     = S_WB;
         end
         S_WB: begin
            EscreveReg = 1'b1;
            SelMuxUlaA = 1'b1;
            if (opcode == OP_R) begin
               SelMuxReg1 = 1'b1;
               SelMuxUlaB = 2'b00;
            end else begin
               SelMuxUlaB = 2'b11;
            end
            w_next = S_FETCH;
         end
         S_BR_ADDR: begin
            SelMuxPC   = 2'b01;
            SelMuxUlaA = 1'b1;
            w_next     = S_BR_COMMIT;
         end
         S_JUMP: begin
            SelMuxUlaA = 1'b1;
            SelMuxUlaB = 2'b11;
            OpULA      = 2'b11;
            if (opcode == OP_JAL && stk_full) begin
               w_fault = 1'b1;
               w_next  = S_HALT;
            end else begin
               EscrevePC = 1'b1;
               push      = (opcode == OP_JAL);
               w_next    = S_FETCH;
            end
         end
         S_BR_COMMIT: begin
            OpULA  = 2'b11;
            w_next = S_FETCH;
            if (opcode == OP_JST) begin
               SelMuxPC = 2'b11;
               if (stk_empty) begin
                  w_fault = 1'b1;
                  w_next  = S_HALT;
               end else begin
                  EscrevePC = 1'b1;
                  pop       = 1'b1;
               end
            end else begin
               EscrevePC = zero;
               SelMuxPC  = 2'b10;
            end
         end
         S_EXEC_I: begin
            SelMuxUlaA = 1'b1;
            SelMuxUlaB = 2'b11;
            w_next     = S_WB;
         end
         S_IN_WAIT: begin
            SelMuxIn = 1'b1;
            if (w_enter_rise) w_next = S_IN_WB;
         end
         S_IN_WB: begin
            EscreveReg = 1'b1;
            SelMuxIn   = 1'b1;
            SelMuxReg2 = 1'b1;
            w_next     = S_FETCH;
         end
         S_HALT: begin
            if (HALT_RESUME != 0 && !r_erro && w_enter_rise) w_next = S_FETCH;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

endmodule

// File: doc/ctrl_mc_param.md
# ctrl_mc_param

Parametrised multicycle control unit, successor to the current fixed-width control FSM. It sits between the instruction register and the datapath muxes/write enables.
- Same ISA and datapath select encoding as the current unit.
- Adds single-edge (posedge) operation, a memory wait-state handshake and edge-detected `enter`.
- Adds stack over/underflow trapping, resumable halt and a saturating retired-instruction counter.
- Exports `OpULA`; the ALU control decoder is instantiated outside this block.

## Interface
Parameters:
- `OPW`, 6: opcode width. ISA codes are zero-extended into it.
- `FW`, 6: funct width. Pass-through only, not decoded here.
- `MEM_WAIT`, 1: 1 = honour `mem_ready`; 0 = `mem_ready` treated as 1.
- `HALT_RESUME`, 1: 1 = an `enter` rising edge leaves HALT when `erro`=0.
- `CNT_W`, 16: width of `instr_cnt`.

Ports:
- `clk` in 1: clock, rising edge only.
- `reset` in 1: asynchronous, active-high.
- `opcode` in OPW: current instruction register opcode field.
- `zero` in 1: ALU zero flag (branch taken).
- `enter` in 1: user input key, level.
- `mem_ready` in 1: memory access complete this cycle.
- `stk_full`, `stk_empty` in 1 each: return-stack status.
- `estado` out 4: current state.
- `EscrevePC`, `EscreveRI`, `EscreveReg`, `EscreveMem`, `controleOUT`, `push`, `pop`, `mem_req` out 1 each: write enables and strobes.
- `SelMuxMem`, `SelMuxReg1`, `SelMuxReg2`, `SelMuxUlaA`, `SelMuxIn` out 1 each: datapath selects.
- `SelMuxUlaB`, `SelMuxPC`, `OpULA` out 2 each: datapath selects and ALU op class.
- `erro` out 1: sticky stack fault.
- `instr_cnt` out CNT_W: retired-instruction count.

## Operation
ISA codes:
- R=0x00; immediate ALU 0x01–0x09.
- beq/bne/blt/bgt 0x0A–0x0D.
- sti 0x0E, ldi 0x0F, str 0x10, ldr 0x11.
- hlt 0x12, in 0x13, out 0x14.
- jmp 0x15, jal 0x16, jst 0x17.

Outputs are a Moore-style combinational decode of `estado`, qualified by `opcode`, `zero`, `mem_ready` and stack flags. Any output not listed for a state is 0. `rdy` = `mem_ready` | ~MEM_WAIT.

States and behaviour:
- 0 FETCH: `mem_req`=1, `EscreveRI`=`rdy`, `SelMuxUlaB`=01, `OpULA`=01, `SelMuxIn`=1. Next state is DECODE when `rdy`, otherwise stay in FETCH.
- 1 DECODE: `EscrevePC`=1 except for hlt; `SelMuxUlaB`=01; `controleOUT`=1 for out. Next state by opcode:
  - out → FETCH
  - in → IN_WAIT
  - sti/ldi/str/ldr → ADDR
  - R → EXEC_R
  - branches → BR_ADDR
  - jmp/jal → JUMP
  - jst → BR_COMMIT
  - hlt → HALT
  - any other code → EXEC_I
- 2 ADDR: `SelMuxMem`=1, `SelMuxUlaA`=1, `SelMuxUlaB`=11. `OpULA`=11 for sti/ldi, else 01. Next is MEM_RD for loads, MEM_WR for stores.
- 3 MEM_RD: `mem_req`=1, `SelMuxMem`=1, `SelMuxReg2`=1. Next is MEM_WB when `rdy`, else stay.
- 4 MEM_WB: `EscreveReg`=1, `SelMuxMem`=1, `SelMuxReg2`=1. Next is FETCH.
- 5 MEM_WR: `mem_req`=1, `EscreveMem`=1, `SelMuxMem`=1, `SelMuxUlaA`=1, `OpULA`=11. Next is FETCH when `rdy`, else stay.
- 6 EXEC_R: `SelMuxReg1`=1, `SelMuxUlaA`=1. Next is WB.
- 7 WB: `EscreveReg`=1, `SelMuxUlaA`=1. For R: `SelMuxReg1`=1, `SelMuxUlaB`=00. Otherwise `SelMuxUlaB`=11. Next is FETCH.
- 8 BR_ADDR: `SelMuxPC`=01, `SelMuxUlaA`=1. Next is BR_COMMIT.
- 9 JUMP: `EscrevePC`=1, `SelMuxUlaA`=1, `SelMuxUlaB`=11, `OpULA`=11, `push`=1 for jal. Next is FETCH.
  - jal with `stk_full`=1: `push`=0 and `EscrevePC`=0, set `erro`, next is HALT.
- 10 BR_COMMIT: `OpULA`=11.
  - jst: `EscrevePC`=1, `pop`=1, `SelMuxPC`=11.
  - Branches: `EscrevePC`=`zero`, `SelMuxPC`=10.
  - Next is FETCH.
  - jst with `stk_empty`=1: `pop`=0 and `EscrevePC`=0, set `erro`, next is HALT.
- 11 EXEC_I: `SelMuxUlaA`=1, `SelMuxUlaB`=11. Next is WB.
- 12 IN_WAIT: `SelMuxIn`=1. Next is IN_WB on `enter_rise`, else stay.
- 13 IN_WB: `EscreveReg`=1, `SelMuxIn`=1, `SelMuxReg2`=1. Exactly one write per `in`. Next is FETCH.
- 14 HALT: all control outputs 0. Next is FETCH on `enter_rise` when HALT_RESUME=1 and `erro`=0, else stay.
- Code 15 is unused. If reached, it decodes like HALT and the next state is FETCH.

Registers and counter rules:
- `enter_q` is a register of `enter`; `enter_rise` = `enter` & ~`enter_q`.
- A level held high from before the wait state does not count as an edge.
- `erro` is set by a stack fault and cleared only by `reset`.
- `instr_cnt` increments by 1 in each DECODE cycle and saturates at 2^CNT_W−1, with no wrap.

## Timing
- Reset asynchronous: `estado`=0 (FETCH), `erro`=0, `enter_q`=0, `instr_cnt`=0.
  - During reset, outputs show FETCH decode with `EscreveRI`=0: `mem_req`=1, `SelMuxUlaB`=01, `OpULA`=01, `SelMuxIn`=1, all else 0.
- Reset asserted mid-instruction aborts it immediately. No write enable may remain high while `reset`=1.
- Latency with `rdy`=1 (cycles from FETCH to next FETCH):
  - out: 2
  - jmp/jal/jst: 3
  - R, immediate, branch, str/sti: 4
  - ldr/ldi: 5
  - in: 4 + cycles waiting for the edge
- Each `mem_ready`=0 cycle in FETCH/MEM_RD/MEM_WR adds one cycle.
- `EscreveMem` stays high through wait cycles. Memory commits on the `rdy` cycle.
- Decisions and state transitions occur on the rising edge of `clk` only.

## Test plan
- Reset then R-type (opcode 0x00), MEM_WAIT=1, `mem_ready`=1: `estado` 0→1→6→7→0. `EscreveReg` high only in state 7. `instr_cnt`=1.
- ldi (0x0F) with `mem_ready` low for 3 cycles in MEM_RD: 8 cycles total. `EscreveReg` pulses once in state 4.
- in (0x13) with `enter` already high on entry: stays in 12 until `enter` drops and rises again. Then one `EscreveReg` cycle.
- jal (0x16) with `stk_full`=1: `push`=0, `erro`=1, `estado`=14. `enter` edge does not leave HALT. Only `reset` clears it.
- beq (0x0A) with `zero`=0, then `zero`=1: `EscrevePC` low, then high in state 10 with `SelMuxPC`=10.
- hlt (0x12), HALT_RESUME=1: DECODE has `EscrevePC`=0. `enter` edge returns to FETCH. With CNT_W=2, five retired instructions give `instr_cnt`=3.
